// File: rtl/xor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xor_pkg
// Description : Shared defaults and helpers for the XOR stream cipher block.
//               DATA_W_DEF / KEY_W_DEF / DEPTH_DEF are the parameter defaults
//               of xor_crypt_stream. rot_src() gives the source bit index for
//               each destination bit of a 1-bit left rotation of the key.
// Revision    : 1.0 - initial release
// ============================================================================
package xor_pkg;

  localparam int DATA_W_DEF = 256;
  localparam int KEY_W_DEF  = 8;
  localparam int DEPTH_DEF  = 4;

  // Key rotate-left-by-one, expressed per destination bit: bit dst of the
  // rotated key comes from bit (dst-1) mod width of the current key, so the
  // MSB wraps into bit 0. Evaluated at elaboration, so it costs only wiring.
  function automatic int rot_src(input int dst, input int width);
    return (dst + width - 1) % width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xor_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xor_fifo
// Description : Synchronous FIFO with first-word-fall-through output.
//               Ports:
//                 clk       - clock, rising edge
//                 rst_n     - synchronous active-low reset (clears pointers
//                             and level; storage is not cleared)
//                 push      - write push_data at the tail (ignored when full)
//                 push_data - WIDTH-bit write data
//                 pop       - remove the head entry (ignored when empty)
//                 pop_data  - head entry, forced to 0 while empty
//                 level     - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module xor_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]     FULL_LVL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]     ONE_LVL  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0]   ONE_PTR  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard both operations locally so the FIFO is safe even if a caller
  // pushes when full or pops when empty.
  assign do_push = push && (level < FULL_LVL);
  assign do_pop  = pop && (level != '0);

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   level <= level + ONE_LVL;
        2'b01:   level <= level - ONE_LVL;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = (level != '0) ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/xor_crypt_stream.sv
`default_nettype none
// ============================================================================
// Module      : xor_crypt_stream
// Description : Streaming XOR cipher with valid/ready handshakes on both
//               sides and an output FIFO. Each accepted word is XORed with
//               the current key replicated across the word, then queued.
//               Ports:
//                 clk        - clock, rising edge
//                 rst_n      - synchronous active-low reset
//                 key_load   - load key_in into the working key
//                 key_in     - KEY_W-bit key value
//                 mode       - 0 static key, 1 rolling key (rotl 1 per beat)
//                 in_valid   - input beat valid
//                 in_ready   - block can accept an input beat
//                 in_data    - DATA_W-bit plaintext
//                 out_valid  - ciphertext beat available
//                 out_ready  - consumer accepts the output beat
//                 out_data   - DATA_W-bit ciphertext (0 while out_valid = 0)
//                 level      - FIFO occupancy
//                 word_count - input beats accepted since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module xor_crypt_stream
  import xor_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_load,
  input  logic [KEY_W-1:0]       key_in,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            word_count
);

  localparam int                      LVL_W    = $clog2(DEPTH) + 1;
  localparam int                      REPS     = DATA_W / KEY_W;
  localparam logic [LVL_W-1:0]        FULL_LVL = LVL_W'(DEPTH);

  // Elaboration-time parameter sanity checks.
  generate
    if ((DATA_W % KEY_W) != 0) begin : g_chk_key_div
      $error("xor_crypt_stream: DATA_W must be a multiple of KEY_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("xor_crypt_stream: DEPTH must be a power of two and >= 2");
    end
  endgenerate

  logic [KEY_W-1:0]  key_cur;
  logic [KEY_W-1:0]  key_rot;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] cipher;

  // in_ready looks only at the registered level, never at out_ready, so a
  // full FIFO stays closed to input on the same edge a pop frees a slot.
  assign in_ready  = (level < FULL_LVL);
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The beat accepted this cycle always sees the key as it is now; any
  // load or rotation lands on the same edge and affects the next beat.
  assign cipher = in_data ^ {REPS{key_cur}};

  generate
    for (genvar b = 0; b < KEY_W; b++) begin : g_rot
      assign key_rot[b] = key_cur[rot_src(b, KEY_W)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_cur    <= '0;
      word_count <= '0;
    end else begin
      if (push) word_count <= word_count + 32'd1;
      if (key_load)          key_cur <= key_in;
      else if (mode && push) key_cur <= key_rot;
    end
  end

  xor_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cipher),
    .pop       (pop),
    .pop_data  (out_data),
    .level     (level)
  );

endmodule
`default_nettype wire

// File: tb/tb_xor_crypt_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_crypt_stream
// Description : Self-checking bench for xor_crypt_stream. A queue-based
//               model tracks the expected ciphertext stream, key and beat
//               count; every cycle the DUT outputs are compared with it.
//               Directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_crypt_stream;

  localparam int DATA_W = 256;
  localparam int KEY_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              key_load;
  logic [KEY_W-1:0]  key_in;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        level;
  logic [31:0]       word_count;

  always #5 clk = ~clk;

  xor_crypt_stream #(
    .DATA_W (DATA_W),
    .KEY_W  (KEY_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key_in     (key_in),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .word_count (word_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rep(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [DATA_W-1:0] rnd256();
    logic [DATA_W-1:0] d;
    for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] q[$];
  logic [7:0]        m_key = 8'h00;
  logic [31:0]       m_wc  = 32'd0;
  bit                started = 1'b0;

  always @(posedge clk) begin
    bit m_push;
    bit m_pop;
    if (!rst_n) begin
      q.delete();
      m_key   = 8'h00;
      m_wc    = 32'd0;
      started = 1'b1;
    end else if (started) begin
      m_push = in_valid && (q.size() < DEPTH);
      m_pop  = out_ready && (q.size() != 0);
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(in_data ^ rep(m_key));
        m_wc = m_wc + 32'd1;
      end
      if (key_load) m_key = key_in;
      else if (mode && m_push) m_key = (m_key << 1) | (m_key >> 7);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", out_valid, (q.size() != 0));
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      else               chk("out_data_idle", out_data, '0);
      chk("level", level, q.size());
      chk("in_ready", in_ready, (q.size() < DEPTH));
      chk("word_count", word_count, m_wc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] d [5];
  logic [7:0]        roll_exp [3];

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key_in = '0; mode = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_word_count", word_count, 0);

    // Static key A5, three zero beats.
    key_load = 1'b1; key_in = 8'hA5; mode = 1'b0; step(); key_load = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("static_valid", out_valid, 1);
      chk("static_data", out_data, rep(8'hA5));
    end
    in_valid = 1'b0;
    chk("static_wc", word_count, 3);
    step();
    chk("static_drained", out_valid, 0);

    // Rolling key 81 -> 03 -> 06.
    roll_exp[0] = 8'h81; roll_exp[1] = 8'h03; roll_exp[2] = 8'h06;
    key_load = 1'b1; key_in = 8'h81; mode = 1'b1; step(); key_load = 1'b0;
    in_valid = 1'b1; in_data = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("roll_data", out_data, rep(roll_exp[i]));
    end
    in_valid = 1'b0; mode = 1'b0;
    step();

    // Backpressure, then full with simultaneous pop.
    key_load = 1'b1; key_in = 8'h5A; step(); key_load = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) d[i] = rnd256();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = d[i]; step();
    end
    chk("bp_level_full", level, 4);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_head", out_data, d[0] ^ rep(8'h5A));
    in_data = d[4]; step();
    chk("bp_blocked_level", level, 4);
    chk("bp_blocked_wc", word_count, 10);
    out_ready = 1'b1; step();
    chk("fullpop_level", level, 3);
    chk("fullpop_in_ready", in_ready, 1);
    chk("fullpop_wc", word_count, 10);
    chk("fullpop_head", out_data, d[1] ^ rep(8'h5A));
    step();
    chk("pushpop_level", level, 3);
    chk("pushpop_wc", word_count, 11);
    in_valid = 1'b0;
    for (int k = 2; k < 5; k++) begin
      chk("bp_drain", out_data, d[k] ^ rep(8'h5A));
      step();
    end
    chk("bp_empty", out_valid, 0);

    // Key load colliding with an accepted beat.
    key_load = 1'b1; key_in = 8'h11; step();
    in_valid = 1'b1; in_data = '0; key_in = 8'h22; step();
    key_load = 1'b0;
    chk("collide_old_key", out_data, rep(8'h11));
    step();
    in_valid = 1'b0;
    chk("collide_new_key", out_data, rep(8'h22));
    step();

    // Reset with entries queued.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = rnd256(); step();
    end
    in_valid = 1'b0;
    chk("prerst_level", level, 3);
    rst_n = 1'b0; key_load = 1'b1; key_in = 8'h77; in_valid = 1'b1; step();
    rst_n = 1'b1; key_load = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_wc", word_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = '0; out_ready = 1'b1; mode = 1'b0; step();
    in_valid = 1'b0;
    chk("midrst_key_zero_valid", out_valid, 1);
    chk("midrst_key_zero_data", out_data, '0);
    step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = (c < 1500) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
      key_load  = ($urandom % 16) == 0;
      key_in    = 8'($urandom);
      if (($urandom % 8) == 0) mode = ~mode;
      in_data   = rnd256();
      rst_n     = ($urandom % 500) != 0;
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; key_load = 1'b0; out_ready = 1'b1;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xor_crypt_stream.md
XOR_CRYPT_STREAM -- requirements
Module: xor_crypt_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning the plaintext/ciphertext word width in bits.
REQ-002 SHALL have parameter KEY_W, default 8, meaning the key width in bits; DATA_W % KEY_W == 0 is checked at elaboration and fails the build otherwise.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the output FIFO depth in entries; it is a power of two and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 SHALL have port key_load, input, 1 bit: loads key_in into the working key.
REQ-007 SHALL have port key_in, input, KEY_W bits: the key value to load.
REQ-008 SHALL have port mode, input, 1 bit: 0 selects a static key, 1 selects a rolling key.
REQ-009 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-010 SHALL have port in_ready, output, 1 bit: the block can accept an input beat.
REQ-011 SHALL have port in_data, input, DATA_W bits: the plaintext word.
REQ-012 SHALL have port out_valid, output, 1 bit: a ciphertext beat is available.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the output beat.
REQ-014 SHALL have port out_data, output, DATA_W bits: the ciphertext word.
REQ-015 SHALL have port level, output, $clog2(DEPTH)+1 bits: the current FIFO occupancy.
REQ-016 SHALL have port word_count, output, 32 bits: the number of input beats accepted since reset.

Function
REQ-017 SHALL accept an input beat (push) on a rising edge where in_valid && in_ready.
REQ-018 SHALL pop an output beat on a rising edge where out_valid && out_ready.
REQ-019 SHALL drive in_ready = (level < DEPTH); in_ready does not depend on a same-cycle pop, so there is no combinational path from out_ready to in_ready.
REQ-020 SHALL form each ciphertext word as in_data XOR {DATA_W/KEY_W{key_cur}}, using the key_cur value present in the cycle the beat is accepted.
REQ-021 SHALL write the ciphertext word of an accepted beat into the FIFO tail on the same edge.
REQ-022 SHALL have a latency of 1 cycle when the FIFO is empty: out_valid is asserted in the cycle after acceptance.
REQ-023 SHALL drive out_valid = (level != 0) and out_data = FIFO head when out_valid = 1.
REQ-024 SHALL drive out_data = 0 whenever out_valid = 0.
REQ-025 SHALL deliver output beats strictly in acceptance order, with no loss and no duplication.
REQ-026 SHALL update key_cur as follows, in priority order: key_load → key_in; else mode==1 && push → key_cur rotated left by 1 bit; else hold.
REQ-027 SHALL apply the rule for key_load coinciding with an accepted beat: that beat uses the old key_cur and the next beat uses key_in.
REQ-028 SHALL apply a mode change from the next accepted beat onward; beats already held in the FIFO are not re-encrypted.
REQ-029 SHALL handle a push and a pop on the same edge as follows: level is unchanged and both operations take effect, including at level == DEPTH when a pop occurs (the push is blocked there because in_ready = 0).
REQ-030 SHALL leave state unchanged when in_valid = 1 and in_ready = 0; the upstream holds the beat.
REQ-031 SHALL ignore a pop attempt while the FIFO is empty (out_ready = 1 with level == 0), leaving the state unchanged.
REQ-032 SHALL increment word_count by 1 on each push and wrap from 32'hFFFF_FFFF to 0.
REQ-033 SHALL wrap the FIFO read/write pointers modulo DEPTH.

Reset
REQ-034 SHALL, on an edge with rst_n = 0, clear key_cur, level, the pointers and word_count to 0, which drives out_valid = 0, out_data = 0 and in_ready = 1 from the following cycle.
REQ-035 SHALL discard all FIFO contents on reset during operation, and ignore key_load and in_valid in that cycle.

Structure
REQ-036 SHALL place the DATA_W/KEY_W/DEPTH defaults and a key-rotate function in the shared package xor_pkg.
REQ-037 SHALL implement the FIFO as the sub-module xor_fifo (parameters WIDTH and DEPTH; push/pop/level interface); the key register and XOR datapath remain in the top module.

Verification
REQ-038 SHALL be verified by a static-key scenario: key_load with key_in = 8'hA5, mode = 0, three beats of in_data = 0 with out_ready = 1 → each out_data is all bytes A5, the first one cycle after acceptance, and word_count = 3.
REQ-039 SHALL be verified by a rolling-key scenario: key_load with key_in = 8'h81, mode = 1, three zero beats → out_data bytes are 81, then 03, then 06.
REQ-040 SHALL be verified by a backpressure scenario: DEPTH = 4, out_ready = 0, five beats offered → in_ready falls after the 4th beat and level = 4; raising out_ready drains all five beats in order.
REQ-041 SHALL be verified by a key-load-collision scenario: key_cur = 8'h11, key_load with key_in = 8'h22 in the same cycle as a zero beat → that beat's out_data is all 11 and the next beat's is all 22.
REQ-042 SHALL be verified by a mid-operation-reset scenario: with 3 entries queued, rst_n = 0 for one edge → out_valid = 0, level = 0, word_count = 0, key_cur = 0 and in_ready = 1 in the next cycle.
REQ-043 SHALL be verified by a full-with-simultaneous-pop scenario: at level = 4 with out_ready = 1 and in_valid = 1 → a pop occurs, no push occurs, level becomes 3, then a push on the next edge.
